// File: rtl/hci_core_mem_responder.sv
// HCI core responder: terminates a req/gnt + r_valid/lrdy stream in a local word-addressed SRAM.
// Reads go through a fixed-latency pipeline into a fall-through response FIFO; grants are credit limited.
module hci_core_mem_responder #(
    parameter int unsigned   DW         = 32,
    parameter int unsigned   AW         = 32,
    parameter int unsigned   UW         = 1,
    parameter int unsigned   NB_WORDS   = 1024,
    parameter logic [AW-1:0] BASE_ADDR  = '0,
    parameter int unsigned   LATENCY    = 1,
    parameter int unsigned   RESP_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [AW-1:0]   add_i,
    input  logic            we_n_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [15:0]     boffs_i,
    input  logic            lrdy_i,
    input  logic [UW-1:0]   user_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_valid_o,
    output logic            r_opc_o,
    output logic [UW-1:0]   r_user_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = $clog2(NB_WORDS);
    localparam int unsigned OW = $clog2(BW);
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [AW:0] SPAN = (AW+1)'(NB_WORDS) * (AW+1)'(BW);

    // Address decode: a borrow out of the subtraction lands above SPAN, so one compare covers both bounds.
    logic [AW:0]    diff;
    logic           in_range;
    logic [IW-1:0]  idx;
    logic           unused_sink;

    assign diff        = {1'b0, add_i} - {1'b0, BASE_ADDR};
    assign in_range    = diff < SPAN;
    assign idx         = diff[OW +: IW];
    assign unused_sink = ^{boffs_i, diff};

    logic [CW-1:0]  outstanding;
    logic           rd_req;
    logic           wr_req;

    assign gnt_o  = rst_ni & !stall_i & (outstanding < CW'(RESP_DEPTH));
    assign rd_req = req_i & gnt_o & we_n_i;
    assign wr_req = req_i & gnt_o & !we_n_i;

    logic [DW-1:0] mem [NB_WORDS];

    always_ff @(posedge clk_i) begin
        if (wr_req && in_range) begin
            for (int unsigned k = 0; k < BW; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    logic [DW-1:0] rd_data;
    logic          rd_opc;

    assign rd_data = in_range ? mem[idx] : '0;
    assign rd_opc  = !in_range;

    logic          push;
    logic [DW-1:0] push_data;
    logic          push_opc;
    logic [UW-1:0] push_user;

    // The SRAM read edge doubles as the first stage, so only LATENCY-1 registers sit before the FIFO.
    if (LATENCY == 1) begin : g_direct
        assign push      = rd_req;
        assign push_data = rd_data;
        assign push_opc  = rd_opc;
        assign push_user = user_i;
    end else begin : g_pipe
        logic [LATENCY-2:0] pv;
        logic [LATENCY-2:0] po;
        logic [DW-1:0]      pd [LATENCY-1];
        logic [UW-1:0]      pu [LATENCY-1];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                pv <= '0;
                po <= '0;
                for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                    pd[i] <= '0;
                    pu[i] <= '0;
                end
            end else begin
                pv[0] <= rd_req;
                po[0] <= rd_opc;
                pd[0] <= rd_data;
                pu[0] <= user_i;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    pv[i] <= pv[i-1];
                    po[i] <= po[i-1];
                    pd[i] <= pd[i-1];
                    pu[i] <= pu[i-1];
                end
            end
        end

        assign push      = pv[LATENCY-2];
        assign push_data = pd[LATENCY-2];
        assign push_opc  = po[LATENCY-2];
        assign push_user = pu[LATENCY-2];
    end

    logic [DW-1:0] f_data [RESP_DEPTH];
    logic          f_opc  [RESP_DEPTH];
    logic [UW-1:0] f_user [RESP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          pop;
    logic [DW-1:0] last_data;
    logic          last_opc;
    logic [UW-1:0] last_user;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign r_valid_o = fifo_cnt != '0;
    assign pop       = r_valid_o & lrdy_i;
    assign r_data_o  = r_valid_o ? f_data[rd_ptr] : last_data;
    assign r_opc_o   = r_valid_o ? f_opc[rd_ptr]  : last_opc;
    assign r_user_o  = r_valid_o ? f_user[rd_ptr] : last_user;

    always_ff @(posedge clk_i) begin
        if (push) begin
            f_data[wr_ptr] <= push_data;
            f_opc[wr_ptr]  <= push_opc;
            f_user[wr_ptr] <= push_user;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            last_data   <= '0;
            last_opc    <= 1'b0;
            last_user   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= next_ptr(rd_ptr);
                last_data <= f_data[rd_ptr];
                last_opc  <= f_opc[rd_ptr];
                last_user <= f_user[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({rd_req, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && fifo_cnt == CW'(RESP_DEPTH)));

    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding <= CW'(RESP_DEPTH));

endmodule

// File: tb/tb_hci_core_mem_responder.sv
// Directed bench for hci_core_mem_responder: LATENCY=1 instance for data/backpressure/reset,
// LATENCY=3 instance for user echo ordering under random lrdy.
module tb_hci_core_mem_responder;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned UW = 1;
    localparam int unsigned BW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          req1  = 1'b0;
    logic          req2  = 1'b0;
    logic          lrdy1 = 1'b1;
    logic          lrdy2 = 1'b1;
    logic [AW-1:0] add   = '0;
    logic          we_n  = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] be    = '0;
    logic [15:0]   boffs = '0;
    logic [UW-1:0] user  = '0;

    logic          gnt1, gnt2, rv1, rv2, opc1, opc2;
    logic [DW-1:0] rd1, rd2;
    logic [UW-1:0] ru1, ru2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hci_core_mem_responder #(
        .DW(DW), .AW(AW), .UW(UW), .NB_WORDS(1024), .BASE_ADDR(32'h0),
        .LATENCY(1), .RESP_DEPTH(4)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req1), .gnt_o(gnt1),
        .add_i(add), .we_n_i(we_n), .data_i(wdata), .be_i(be), .boffs_i(boffs),
        .lrdy_i(lrdy1), .user_i(user), .r_data_o(rd1), .r_valid_o(rv1),
        .r_opc_o(opc1), .r_user_o(ru1)
    );

    hci_core_mem_responder #(
        .DW(DW), .AW(AW), .UW(UW), .NB_WORDS(1024), .BASE_ADDR(32'h0),
        .LATENCY(3), .RESP_DEPTH(4)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(1'b0), .req_i(req2), .gnt_o(gnt2),
        .add_i(add), .we_n_i(we_n), .data_i(wdata), .be_i(be), .boffs_i(boffs),
        .lrdy_i(lrdy2), .user_i(user), .r_data_o(rd2), .r_valid_o(rv2),
        .r_opc_o(opc2), .r_user_o(ru2)
    );

    typedef struct {
        logic          we_n;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic          user;
        logic [31:0]   exp_data;
        logic          exp_opc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input bit sel, input logic wn, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b,
                         input logic [UW-1:0] u, output int gcyc, output int waited);
        we_n  = wn;
        add   = a;
        wdata = d;
        be    = b;
        user  = u;
        if (sel) req2 = 1'b1;
        else     req1 = 1'b1;
        gcyc   = -1;
        waited = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((sel ? gnt2 : gnt1) === 1'b1) begin
                gcyc = cyc;
                break;
            end
            waited++;
        end
        if (gcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant within 20 cycles");
        end
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    task automatic wait_resp1(output logic [DW-1:0] d, output logic o,
                              output logic [UW-1:0] u, output int vcyc);
        vcyc = -1;
        d    = '0;
        o    = 1'b0;
        u    = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rv1 === 1'b1) begin
                d    = rd1;
                o    = opc1;
                u    = ru1;
                vcyc = cyc;
                break;
            end
        end
    endtask

    function automatic logic [31:0] bp_data(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h0101;
    endfunction

    initial begin
        int            gc, wt, vc, grants, ri, rk, gi, rk2;
        logic [DW-1:0] d;
        logic          o, g, v, l, seen0;
        logic [UW-1:0] u;
        int            gc2[3];
        logic [31:0]   l3_data[3];
        logic          l3_user[3];

        vecs[0]  = '{1'b0, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h10,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h20,   32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h20,   32'h11223344, 4'h5, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h20,   32'h0,        4'h0, 1'b0, 32'hFF22FF44, 1'b0};
        vecs[5]  = '{1'b0, 32'h20,   32'h00000000, 4'h0, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 32'h20,   32'h0,        4'h0, 1'b1, 32'hFF22FF44, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h1000, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'h1000, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h0,    32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b0, 32'hFFC,  32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 32'hFFC,  32'h0,        4'h0, 1'b1, 32'hA5A5A5A5, 1'b0};
        vecs[13] = '{1'b1, 32'h13,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0};

        l3_data = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        l3_user = '{1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt1", gnt1, 0);
        check("rst_gnt2", gnt2, 0);
        check("rst_valid", rv1, 0);
        check("rst_data", rd1, 0);
        check("rst_opc", opc1, 0);
        check("rst_user", ru1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven single transactions, lrdy held high
        foreach (vecs[i]) begin
            issue(1'b0, vecs[i].we_n, vecs[i].addr, vecs[i].data, vecs[i].be,
                  vecs[i].user, gc, wt);
            check($sformatf("v%0d_gnt_wait", i), wt, 0);
            if (vecs[i].we_n) begin
                wait_resp1(d, o, u, vc);
                check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
                check($sformatf("v%0d_opc", i), o, vecs[i].exp_opc);
                check($sformatf("v%0d_user", i), u, vecs[i].user);
                check($sformatf("v%0d_latency", i), vc - gc, 1);
            end
        end

        // Backpressure: 6 reads with lrdy low, only 4 credits
        for (int k = 0; k < 6; k++) begin
            issue(1'b0, 1'b0, 32'h100 + 32'(k) * 4, bp_data(k), 4'hF, 1'b0, gc, wt);
        end
        lrdy1  = 1'b0;
        we_n   = 1'b1;
        ri     = 0;
        grants = 0;
        add    = 32'h100;
        req1   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            g = gnt1 & req1;
            if (g) grants++;
            @(posedge clk);
            #1;
            if (g) begin
                ri++;
                add = 32'h100 + 32'(ri) * 4;
            end
        end
        check("bp_grants_stalled", grants, 4);
        @(negedge clk);
        check("bp_gnt_low", gnt1, 0);
        check("bp_hold_valid", rv1, 1);
        check("bp_hold_data", rd1, bp_data(0));
        lrdy1 = 1'b1;
        rk    = 0;
        for (int c = 0; c < 40 && rk < 6; c++) begin
            g = gnt1 & req1;
            v = rv1;
            if (v) begin
                check($sformatf("bp_resp%0d", rk), rd1, bp_data(rk));
                rk++;
            end
            if (g) grants++;
            @(posedge clk);
            #1;
            if (g) begin
                ri++;
                if (ri < 6) add = 32'h100 + 32'(ri) * 4;
                else        req1 = 1'b0;
            end
            @(negedge clk);
        end
        req1 = 1'b0;
        check("bp_resp_count", rk, 6);
        check("bp_grants_total", grants, 6);

        // LATENCY=3 instance: user echo and latency with random lrdy
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 1'b0, 32'(k) * 4, l3_data[k], 4'hF, 1'b0, gc, wt);
        end
        lrdy2 = 1'b0;
        we_n  = 1'b1;
        gi    = 0;
        rk2   = 0;
        seen0 = 1'b0;
        add   = 32'h0;
        user  = l3_user[0];
        req2  = 1'b1;
        for (int c = 0; c < 80 && rk2 < 3; c++) begin
            @(negedge clk);
            g = gnt2 & req2;
            v = rv2;
            l = lrdy2;
            if (g) gc2[gi] = cyc;
            if (v && rk2 == 0 && !seen0) begin
                seen0 = 1'b1;
                check("l3_first_latency", cyc - gc2[0], 3);
            end
            if (v && l) begin
                check($sformatf("l3_user%0d", rk2), ru2, l3_user[rk2]);
                check($sformatf("l3_data%0d", rk2), rd2, l3_data[rk2]);
                check($sformatf("l3_lat%0d", rk2), (cyc - gc2[rk2]) >= 3, 1);
                rk2++;
            end
            @(posedge clk);
            #1;
            if (g) begin
                gi++;
                if (gi < 3) begin
                    add  = 32'(gi) * 4;
                    user = l3_user[gi];
                end else begin
                    req2 = 1'b0;
                end
            end
            lrdy2 = 1'($urandom_range(0, 1));
        end
        req2 = 1'b0;
        check("l3_resp_count", rk2, 3);

        // Reset with two reads in flight
        lrdy1 = 1'b0;
        issue(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, gc, wt);
        issue(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, gc, wt);
        rst_n = 1'b0;
        req1  = 1'b1;
        we_n  = 1'b1;
        add   = 32'h10;
        @(negedge clk);
        check("rst_mid_gnt", gnt1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req1  = 1'b0;
        lrdy1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst_flush_valid%0d", c), rv1, 0);
        end

        // Stall blocks grants regardless of req
        @(posedge clk);
        #1;
        stall = 1'b1;
        req1  = 1'b1;
        lrdy1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_gnt%0d", c), gnt1, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_no_resp", rv1, 0);
        @(posedge clk);
        #1;
        stall  = 1'b0;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (gnt1 & req1) grants++;
            @(posedge clk);
            #1;
        end
        check("post_rst_credits", grants, 4);
        req1  = 1'b0;
        lrdy1 = 1'b1;
        repeat (8) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
